lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
Load/store sequencer directly upstream of the data memory. It accepts one memory request at a time from execute over a valid/ready handshake and checks alignment and opcode/direction consistency. It then drives the memory's combinational address, write data, write-enable and control lines for exactly one cycle. It captures the read data and returns a registered response with error flags to writeback.

Parameters:
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ReqValid  in  1  request present
ReqReady  out  1  block can accept a request
ReqWr  in  1  1=store, 0=load
ReqCtrl  in  3  access type: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 110, SH 111, SW 011
ReqAddr  in  32  byte address
ReqData  in  32  store data
RspValid  out  1  response present
RspReady  in  1  consumer accepts response
RspData  out  32  load result (0 for stores and errors)
RspMisalign  out  1  access was misaligned, not performed
RspIllegal  out  1  ReqWr inconsistent with ReqCtrl, not performed
MemAddress  out  32  to memory Address
MemDataWr  out  32  to memory DataWr
MemWr  out  1  to memory DMWr
MemCtrl  out  3  to memory DMCtrl
MemDataRd  in  32  from memory DataRd
ErrCnt  out  ERR_CNT_W  saturating count of misaligned plus illegal requests

Behaviour:
- Clocking: one clock (clk); reset synchronous, active-high (rst). Every register updates on the rising edge of clk only.
- FSM states: IDLE, ACCESS, RESP. Reset value is IDLE.
- IDLE:
  - ReqReady=1. Handshake fires when ReqValid&ReqReady at a rising edge.
  - On handshake, latch ReqWr, ReqCtrl, ReqAddr and ReqData into registers.
- Size decode on ReqCtrl:
  - Byte: 000, 100, 110.
  - Half: 001, 101, 111. Requires addr[0]=0.
  - Word: 010, 011. Requires addr[1:0]=00.
- Store codes are 110, 111 and 011. Every other code is a load.
- Illegal: ReqWr=1 with a load code, or ReqWr=0 with a store code. Illegal takes priority over misalign; only RspIllegal is set.
- On handshake with an error: go directly to RESP with RspData=0 and the matching flag set. The ACCESS state is skipped and MemWr is never asserted. ErrCnt increments and saturates at all-ones.
- On handshake with no error: go to ACCESS.
- ACCESS (exactly 1 cycle):
  - MemAddress = latched address, MemDataWr = latched data, MemCtrl = latched ctrl, MemWr = latched ReqWr.
  - At the closing edge: loads register RspData<=MemDataRd; stores register RspData<=0. Both clear the flags, then go to RESP.
- RESP:
  - RspValid=1. RspData and flags are held stable until RspReady.
  - On RspValid&RspReady, go to IDLE.
  - No new request is accepted in this same cycle; ReqReady=0.
- Outputs outside ACCESS:
  - MemWr=0.
  - MemAddress, MemDataWr and MemCtrl hold the last latched values (reset 0, 0, 3'b010). This keeps the combinational read stable.
- MemWr = (state==ACCESS) & wr_q & ~rst. A reset asserted during ACCESS blocks the write in that same cycle.
- Latency:
  - Handshake at edge N puts the block in ACCESS during cycle N+1. RspValid is high from edge N+2.
  - For errors, RspValid is high from edge N+1.
  - Throughput is at most one request per 3 cycles, or 2 cycles for errors, assuming RspReady is held high.
- Reset values: ReqReady=1 (IDLE), RspValid=0, RspData=0, RspMisalign=0, RspIllegal=0, MemWr=0, MemAddress=0, MemDataWr=0, MemCtrl=3'b010, ErrCnt=0.
- Reset mid-operation: any state returns to IDLE and any pending response is discarded. ErrCnt clears.
- Backpressure: RspReady=0 holds RESP indefinitely with all Rsp outputs stable. ReqValid is ignored while in RESP.

Test Plan:
- Reset, then LW of 0x0000_0010 with memory word 4 = 0xDEAD_BEEF. Required: MemWr=0 in ACCESS; RspValid two cycles after handshake; RspData=0xDEADBEEF; both flags 0.
- SB to 0x0000_0013 with data 0x0000_00A5. Required: MemWr=1 for exactly one cycle with MemCtrl=110 and MemAddress=0x13. A following LBU of 0x13 returns 0x0000_00A5 and an LB returns 0xFFFF_FFA5.
- LH of 0x0000_0001. Required: RspMisalign=1, RspData=0, RspValid one cycle after handshake, MemWr never 1, ErrCnt=1.
- ReqWr=1 with ReqCtrl=010 and an aligned address. Required: RspIllegal=1 and RspMisalign=0, no write, ErrCnt increments. With 300 such errors, ErrCnt saturates at 255.
- SW to 0x20 with data 0x1234_5678 while RspReady is held 0 for 5 cycles. Required: RspValid stays 1 with stable outputs, ReqReady=0, and a concurrent ReqValid is not accepted. Releasing RspReady returns the block to IDLE the next cycle.
- rst asserted during the ACCESS cycle of an SW. Required: MemWr=0 in that cycle, memory unchanged, and all outputs at reset values after the edge.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Bundle of the execute-side request, writeback-side response and data-memory
// signals around the load/store sequencer.
interface lsu_ctrl_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWr;
    logic [2:0]  ReqCtrl;
    logic [31:0] ReqAddr;
    logic [31:0] ReqData;
    logic        RspValid;
    logic        RspReady;
    logic [31:0] RspData;
    logic        RspMisalign;
    logic        RspIllegal;
    logic [31:0] MemAddress;
    logic [31:0] MemDataWr;
    logic        MemWr;
    logic [2:0]  MemCtrl;
    logic [31:0] MemDataRd;

    modport slave (
        input  ReqValid, ReqWr, ReqCtrl, ReqAddr, ReqData, RspReady, MemDataRd,
        output ReqReady, RspValid, RspData, RspMisalign, RspIllegal,
               MemAddress, MemDataWr, MemWr, MemCtrl
    );

    modport master (
        output ReqValid, ReqWr, ReqCtrl, ReqAddr, ReqData, RspReady, MemDataRd,
        input  ReqReady, RspValid, RspData, RspMisalign, RspIllegal,
               MemAddress, MemDataWr, MemWr, MemCtrl
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: takes one request at a time, validates alignment and
// direction, drives the data memory for one cycle and returns a registered response.
module lsu_ctrl #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    lsu_ctrl_if.slave            bus,
    output logic [ERR_CNT_W-1:0] ErrCnt
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               state;
    logic                 wr_q;
    logic [2:0]           ctrl_q;
    logic [31:0]          addr_q;
    logic [31:0]          data_q;
    logic                 req_ready;
    logic                 rsp_valid;
    logic [31:0]          rsp_data;
    logic                 rsp_misalign;
    logic                 rsp_illegal;
    logic [ERR_CNT_W-1:0] err_cnt;

    logic is_store;
    logic is_half;
    logic is_word;
    logic illegal;
    logic misalign;
    logic handshake;

    always_comb begin
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (bus.ReqCtrl)
            3'b001, 3'b101: is_half = 1'b1;
            3'b111: begin
                is_half  = 1'b1;
                is_store = 1'b1;
            end
            3'b010: is_word = 1'b1;
            3'b011: begin
                is_word  = 1'b1;
                is_store = 1'b1;
            end
            3'b110: is_store = 1'b1;
            default: ;
        endcase
    end

    assign illegal   = bus.ReqWr != is_store;
    assign misalign  = (is_half & bus.ReqAddr[0]) | (is_word & (|bus.ReqAddr[1:0]));
    assign handshake = bus.ReqValid & req_ready;

    // Rejected requests skip ACCESS so the memory never sees them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_q         <= 1'b0;
            ctrl_q       <= 3'b010;
            addr_q       <= 32'h0;
            data_q       <= 32'h0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_data     <= 32'h0;
            rsp_misalign <= 1'b0;
            rsp_illegal  <= 1'b0;
            err_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        wr_q      <= bus.ReqWr;
                        ctrl_q    <= bus.ReqCtrl;
                        addr_q    <= bus.ReqAddr;
                        data_q    <= bus.ReqData;
                        req_ready <= 1'b0;
                        if (illegal || misalign) begin
                            rsp_data     <= 32'h0;
                            rsp_illegal  <= illegal;
                            rsp_misalign <= misalign & ~illegal;
                            rsp_valid    <= 1'b1;
                            state        <= RESP;
                            if (err_cnt != {ERR_CNT_W{1'b1}})
                                err_cnt <= err_cnt + ERR_CNT_W'(1);
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    rsp_data     <= wr_q ? 32'h0 : bus.MemDataRd;
                    rsp_illegal  <= 1'b0;
                    rsp_misalign <= 1'b0;
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.RspReady) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Gating with rst stops a write in the very cycle reset arrives.
    assign bus.MemWr       = (state == ACCESS) & wr_q & ~rst;
    assign bus.MemAddress  = addr_q;
    assign bus.MemDataWr   = data_q;
    assign bus.MemCtrl     = ctrl_q;
    assign bus.ReqReady    = req_ready;
    assign bus.RspValid    = rsp_valid;
    assign bus.RspData     = rsp_data;
    assign bus.RspMisalign = rsp_misalign;
    assign bus.RspIllegal  = rsp_illegal;
    assign ErrCnt          = err_cnt;
endmodule
